// File: rtl/prog_loader.sv
// Instruction-memory loader: assembles little-endian words from a byte stream,
// writes them to instruction memory, then runs the processor and captures the test result.
module prog_loader #(
    parameter int MAX_WORDS      = 512,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        rxValid,
    input  logic [7:0]  rxData,
    output logic        rxReady,
    output logic        insMemEn,
    output logic [31:0] insMemAddr,
    output logic [31:0] insMemDataIn,
    output logic        cpuReset,
    input  logic        ecallSeen,
    input  logic        passFlag,
    output logic        busy,
    output logic        testDone,
    output logic        testPass,
    output logic        testTimeout,
    output logic [31:0] wordCount,
    output logic [1:0]  loaderState
);

    // Handshake: a byte moves on a rising edge where rxValid and rxReady are both high;
    // rxReady is registered and does not depend on rxValid in the same cycle.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] MAX_WORDS_W   = 32'(MAX_WORDS);
    localparam logic [31:0] TIMEOUT_LAST  = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [1:0]  byteIdx;
    logic [23:0] asmWord;
    logic [31:0] runCount;
    logic [31:0] fullWord;
    logic [31:0] nextCount;
    logic        byteTake;

    assign byteTake    = rxValid & rxReady;
    assign fullWord    = {rxData, asmWord};
    assign nextCount   = wordCount + 32'd1;
    assign loaderState = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rxReady      <= 1'b0;
            insMemEn     <= 1'b0;
            insMemAddr   <= 32'd0;
            insMemDataIn <= 32'd0;
            cpuReset     <= 1'b1;
            busy         <= 1'b0;
            testDone     <= 1'b0;
            testPass     <= 1'b0;
            testTimeout  <= 1'b0;
            wordCount    <= 32'd0;
            byteIdx      <= 2'd0;
            asmWord      <= 24'd0;
            runCount     <= 32'd0;
        end else begin
            insMemEn <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= LOAD;
                        rxReady     <= 1'b1;
                        busy        <= 1'b1;
                        cpuReset    <= 1'b1;
                        testDone    <= 1'b0;
                        testPass    <= 1'b0;
                        testTimeout <= 1'b0;
                        wordCount   <= 32'd0;
                        byteIdx     <= 2'd0;
                        asmWord     <= 24'd0;
                    end
                end

                LOAD: begin
                    if (byteTake) begin
                        if (byteIdx != 2'd3) begin
                            case (byteIdx)
                                2'd0:    asmWord[7:0]   <= rxData;
                                2'd1:    asmWord[15:8]  <= rxData;
                                default: asmWord[23:16] <= rxData;
                            endcase
                            byteIdx <= byteIdx + 2'd1;
                        end else begin
                            byteIdx <= 2'd0;
                            asmWord <= 24'd0;
                            if (fullWord == 32'd0) begin
                                // all-zero word terminates the program image
                                state    <= RUN;
                                rxReady  <= 1'b0;
                                cpuReset <= 1'b0;
                                runCount <= 32'd0;
                            end else begin
                                insMemEn     <= 1'b1;
                                insMemAddr   <= wordCount;
                                insMemDataIn <= fullWord;
                                wordCount    <= nextCount;
                                if (nextCount == MAX_WORDS_W) begin
                                    state    <= RUN;
                                    rxReady  <= 1'b0;
                                    cpuReset <= 1'b0;
                                    runCount <= 32'd0;
                                end
                            end
                        end
                    end
                end

                RUN: begin
                    if (ecallSeen) begin
                        state       <= DONE;
                        cpuReset    <= 1'b1;
                        busy        <= 1'b0;
                        testDone    <= 1'b1;
                        testPass    <= passFlag;
                        testTimeout <= 1'b0;
                    end else if (runCount == TIMEOUT_LAST) begin
                        state       <= DONE;
                        cpuReset    <= 1'b1;
                        busy        <= 1'b0;
                        testDone    <= 1'b1;
                        testPass    <= 1'b0;
                        testTimeout <= 1'b1;
                    end else begin
                        runCount <= runCount + 32'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a small memory and short timeout so
// saturation and timeout paths are reachable quickly.
module tb_prog_loader;

    localparam int MAX_W = 4;
    localparam int TOUT  = 50;

    logic        clock;
    logic        reset;
    logic        start;
    logic        rxValid;
    logic [7:0]  rxData;
    logic        rxReady;
    logic        insMemEn;
    logic [31:0] insMemAddr;
    logic [31:0] insMemDataIn;
    logic        cpuReset;
    logic        ecallSeen;
    logic        passFlag;
    logic        busy;
    logic        testDone;
    logic        testPass;
    logic        testTimeout;
    logic [31:0] wordCount;
    logic [1:0]  loaderState;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    prog_loader #(.MAX_WORDS(MAX_W), .TIMEOUT_CYCLES(TOUT)) dut (
        .clock(clock), .reset(reset), .start(start),
        .rxValid(rxValid), .rxData(rxData), .rxReady(rxReady),
        .insMemEn(insMemEn), .insMemAddr(insMemAddr), .insMemDataIn(insMemDataIn),
        .cpuReset(cpuReset), .ecallSeen(ecallSeen), .passFlag(passFlag),
        .busy(busy), .testDone(testDone), .testPass(testPass),
        .testTimeout(testTimeout), .wordCount(wordCount), .loaderState(loaderState)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every memory write must match the head of exp_q
    always @(negedge clock) begin
        if (insMemEn) begin
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
                check("write_addr_data", {insMemAddr, insMemDataIn}, exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rxValid = 1'b1;
        rxData  = b;
        while (!rxReady && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("rx_ready_wait", 64'(rxReady), 64'd1);
        @(negedge clock);
        rxValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] addr);
        if (w != 32'd0) exp_q.push_back({addr, w});
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic ecall(input logic pass);
        ecallSeen = 1'b1;
        passFlag  = pass;
        @(negedge clock);
        ecallSeen = 1'b0;
        passFlag  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rxReady"},  64'(rxReady), 64'd0);
        check({tag, "_insMemEn"}, 64'(insMemEn), 64'd0);
        check({tag, "_addr"},     64'(insMemAddr), 64'd0);
        check({tag, "_data"},     64'(insMemDataIn), 64'd0);
        check({tag, "_cpuReset"}, 64'(cpuReset), 64'd1);
        check({tag, "_busy"},     64'(busy), 64'd0);
        check({tag, "_status"},   64'({testDone, testPass, testTimeout}), 64'd0);
        check({tag, "_wordCount"}, 64'(wordCount), 64'd0);
        check({tag, "_state"},    64'(loaderState), 64'd0);
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; rxValid = 1'b0; rxData = 8'd0;
        ecallSeen = 1'b0; passFlag = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("por");
        reset = 1'b1;
        @(negedge clock);
        check("idle_rxReady", 64'(rxReady), 64'd0);

        // 1: three-word program plus terminator
        pulse_start();
        check("load_rxReady", 64'(rxReady), 64'd1);
        check("load_busy", 64'(busy), 64'd1);
        send_word(32'h0000_0513, 32'd0);
        send_word(32'h05D0_0893, 32'd1);
        send_word(32'h0010_0193, 32'd2);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        check("pre_term_cpuReset", 64'(cpuReset), 64'd1);
        send_byte(8'h00);
        check("run_cpuReset", 64'(cpuReset), 64'd0);
        check("run_rxReady", 64'(rxReady), 64'd0);
        check("t1_wordCount", 64'(wordCount), 64'd3);
        check("run_state", 64'(loaderState), 64'd2);

        // 2: pass result
        ecall(1'b1);
        check("t2_status", 64'({testDone, testPass, testTimeout}), 64'b110);
        check("t2_cpuReset", 64'(cpuReset), 64'd1);
        check("t2_busy", 64'(busy), 64'd0);

        // 3: fail result, then restart clears status
        pulse_start();
        check("t3_done_cleared", 64'(testDone), 64'd0);
        check("t3_wc_cleared", 64'(wordCount), 64'd0);
        send_word(32'h0000_0513, 32'd0);
        send_word(32'h05D0_0893, 32'd1);
        send_word(32'h0010_0193, 32'd2);
        send_word(32'h0, 32'd0);
        ecall(1'b0);
        check("t3_status", 64'({testDone, testPass, testTimeout}), 64'b100);
        pulse_start();
        check("t3_restart_done", 64'(testDone), 64'd0);
        check("t3_restart_wc", 64'(wordCount), 64'd0);

        // 4: timeout after TOUT run cycles
        send_word(32'h1234_5678, 32'd0);
        send_word(32'h0, 32'd0);
        n = 1;
        while (!testDone && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("t4_run_cycles", 64'(n - 1), 64'(TOUT));
        check("t4_status", 64'({testDone, testPass, testTimeout}), 64'b101);
        check("t4_cpuReset", 64'(cpuReset), 64'd1);

        // 5: saturation at MAX_W words without terminator
        pulse_start();
        send_word(32'h1111_1111, 32'd0);
        send_word(32'h2222_2222, 32'd1);
        send_word(32'h3333_3333, 32'd2);
        send_word(32'h4444_4444, 32'd3);
        check("t5_state", 64'(loaderState), 64'd2);
        check("t5_wordCount", 64'(wordCount), 64'(MAX_W));
        rxValid = 1'b1;
        rxData  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            check("t5_rxReady_low", 64'(rxReady), 64'd0);
            @(negedge clock);
        end
        rxValid = 1'b0;
        ecall(1'b1);
        check("t5_done_state", 64'(loaderState), 64'd3);

        // 6: reset mid-word, then clean reload
        pulse_start();
        send_word(32'hAAAA_AAAA, 32'd0);
        send_byte(8'hBB);
        send_byte(8'hCC);
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        pulse_start();
        send_word(32'h0BAD_F00D, 32'd0);
        pulse_start();
        check("t6_start_ignored", 64'(wordCount), 64'd1);
        send_word(32'h00C0_FFEE, 32'd1);
        send_word(32'h0, 32'd0);
        check("t6_wordCount", 64'(wordCount), 64'd2);
        check("t6_cpuReset", 64'(cpuReset), 64'd0);

        @(negedge clock);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Hardware counterpart to the processor's instruction-memory load port. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes each word into instruction memory through the insMemEn/insMemAddr/insMemDataIn port, then releases the processor from reset and monitors the test-completion indications. It sits between a host link (UART/JTAG byte FIFO) and the processor top, replacing bench-driven program loading on silicon/FPGA.

Parameters:
MAX_WORDS, 512, instruction memory depth in words; loading stops when reached.
TIMEOUT_CYCLES, 100000, processor run cycles before a test is declared timed out.

Ports:
clock  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
start  input  1  single-cycle pulse; begins a load; honoured only in IDLE or DONE.
rxValid  input  1  byte available on rxData.
rxData  input  8  stream byte.
rxReady  output  1  loader accepts a byte this cycle.
insMemEn  output  1  instruction memory write enable, one-cycle pulse per word.
insMemAddr  output  32  word address of the write, zero-extended.
insMemDataIn  output  32  word written.
cpuReset  output  1  active-high reset to the processor.
ecallSeen  input  1  processor signals test end (x17 == 93).
passFlag  input  1  processor pass indication (x3 == 1), sampled with ecallSeen.
busy  output  1  high in LOAD or RUN.
testDone  output  1  high in DONE.
testPass  output  1  result; valid while testDone.
testTimeout  output  1  run ended by timeout; valid while testDone.
wordCount  output  32  number of words written in the current/last load.

Behaviour:
- Reset (reset=0, asynchronous, any state, including mid-word or mid-run):
  - state=IDLE; rxReady=0; insMemEn=0; insMemAddr=0; insMemDataIn=0; cpuReset=1.
  - busy=0; testDone=0; testPass=0; testTimeout=0; wordCount=0.
  - Byte index, assembly register and cycle counter all cleared; partial words are discarded.
- All outputs are registered. States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cpuReset=1, rxReady=0.
  - start -> LOAD; clears wordCount, byte index, testDone, testPass and testTimeout.
- LOAD:
  - cpuReset=1, rxReady=1. A byte transfers when rxValid & rxReady at a rising edge.
  - Byte k of a word (k=0..3) goes to bits [8k+7:8k] (little-endian).
  - On the edge accepting byte 3, with assembled word W:
    - W == 0: terminator. No write; go to RUN.
    - W != 0: next cycle insMemEn=1, insMemAddr=wordCount, insMemDataIn=W for exactly one cycle, and wordCount increments on that same edge. If the new wordCount == MAX_WORDS, go to RUN on that edge.
  - rxReady stays 1 during the write cycle; back-to-back bytes are accepted at one per cycle.
  - rxReady drops the cycle after the transition out of LOAD.
  - start is ignored in this state.
- RUN:
  - cpuReset=0 from the first cycle in RUN; rxReady=0; the cycle counter increments each cycle.
  - ecallSeen=1 sampled at an edge -> DONE, testPass=passFlag, testTimeout=0.
  - Counter reaching TIMEOUT_CYCLES -> DONE, testTimeout=1, testPass=0.
  - If ecallSeen and the timeout coincide, ecallSeen wins.
- DONE:
  - cpuReset=1 from the first DONE cycle; testDone, testPass and testTimeout are held.
  - start -> LOAD, clearing status; instruction memory is not cleared.
- insMemEn is never asserted outside LOAD or the single write cycle that follows the final accepted byte.
- wordCount saturates at MAX_WORDS; insMemAddr never exceeds MAX_WORDS-1.

Test Plan:
1. reset low, then high; start; send bytes for 0x00000513, 0x05D00893, 0x00100193, then 00 00 00 00.
   -> insMemEn pulses at addr 0/1/2 with exactly those data; wordCount=3; cpuReset falls the cycle after the last terminator byte.
2. After case 1, hold ecallSeen=1 with passFlag=1 for one cycle.
   -> next cycle testDone=1, testPass=1, testTimeout=0, cpuReset=1, busy=0.
3. Repeat the load; ecallSeen=1 with passFlag=0.
   -> testDone=1, testPass=0; then a start pulse clears testDone and wordCount to 0 on the next edge.
4. TIMEOUT_CYCLES=50, load one word plus terminator, never assert ecallSeen.
   -> testDone=1, testTimeout=1, testPass=0 after 50 RUN cycles.
5. MAX_WORDS=4, send 4 nonzero words with no terminator.
   -> 4 writes at addr 0..3; RUN entered on the 4th write edge; further rxValid bytes see rxReady=0.
6. reset low after 2 bytes of the second word, then high and restart with 2 words.
   -> all outputs at reset values during reset; the new load writes addr 0 and 1 with no stale bytes.
